// File: rtl/intr_prio_encoder_if.sv
// Request/grant bundle between interrupt sources, the encoder and the control FSM.
// master drives requests, mask, priority level and ack; slave is the encoder.
interface intr_prio_encoder_if #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
);
    logic [N_REQ-1:0] req;
    logic             mask_we;
    logic [N_REQ-1:0] mask_in;
    logic [IDX_W-1:0] cur_pl;
    logic             irq_ack;
    logic             irq_valid;
    logic [IDX_W-1:0] irq_vec;
    logic [N_REQ-1:0] pending_o;

    modport master (
        output req, mask_we, mask_in, cur_pl, irq_ack,
        input  irq_valid, irq_vec, pending_o
    );

    modport slave (
        input  req, mask_we, mask_in, cur_pl, irq_ack,
        output irq_valid, irq_vec, pending_o
    );
endinterface

// File: rtl/intr_prio_encoder.sv
// 8-to-3 registered interrupt priority encoder with edge-latched pending bits,
// mask, priority-level filter and a valid/ack grant handshake.
module intr_prio_encoder #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    intr_prio_encoder_if.slave    bus
);
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] mask_q, mask_d;
    logic [IDX_W-1:0] vec_q, vec_d;

    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] clr;
    logic [IDX_W-1:0] hi_idx;
    logic             ack_acc;

    assign rise    = bus.req & ~req_q;
    assign ack_acc = (state_q == PRESENT) && bus.irq_ack;

    // Eligibility filter and highest-index search over pending lines
    always_comb begin
        elig   = '0;
        hi_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = pending_q[i] & mask_q[i] & (IDX_W'(i) > bus.cur_pl);
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (elig[i]) hi_idx = IDX_W'(i);
        end
    end

    // Pending and mask next state; a new rise beats a same-cycle ack clear
    always_comb begin
        clr = '0;
        if (ack_acc) clr[vec_q] = 1'b1;
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = bus.mask_we ? bus.mask_in : mask_q;
    end

    // Grant FSM: load vector from IDLE, hold it until acked
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        unique case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    vec_d   = hi_idx;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.irq_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= bus.req;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            vec_q     <= vec_d;
        end
    end

    assign bus.irq_valid = (state_q == PRESENT);
    assign bus.irq_vec   = vec_q;
    assign bus.pending_o = pending_q;
endmodule

// File: tb/tb_intr_prio_encoder.sv
// Directed bench for intr_prio_encoder: latency, priority order, PL filter,
// masking, no-preemption, set-wins-over-clear and reset while presenting.
module tb_intr_prio_encoder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    intr_prio_encoder_if #(.N_REQ(8), .IDX_W(3)) bus ();

    intr_prio_encoder #(.N_REQ(8), .IDX_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] vec,
                           input logic [7:0] pend);
        chk({tag, "_valid"}, {7'd0, bus.irq_valid}, {7'd0, v});
        if (v) chk({tag, "_vec"}, {5'd0, bus.irq_vec}, {5'd0, vec});
        chk({tag, "_pend"}, bus.pending_o, pend);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.req     = 8'h00;
        bus.mask_we = 1'b0;
        bus.mask_in = 8'h00;
        bus.cur_pl  = 3'd0;
        bus.irq_ack = 1'b0;
        step();
        step();
        chk_out("rst", 1'b0, 3'd0, 8'h00);
        chk("rst_vec", {5'd0, bus.irq_vec}, 8'h00);
        rst = 1'b0;
        step();

        // 1: single request, two-cycle latency, ack clears
        bus.req = 8'h20;
        step();
        chk_out("t1_lat1", 1'b0, 3'd0, 8'h20);
        step();
        chk_out("t1_grant", 1'b1, 3'd5, 8'h20);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk_out("t1_ack", 1'b0, 3'd0, 8'h00);
        chk("t1_vec_hold", {5'd0, bus.irq_vec}, 8'h05);
        bus.req = 8'h00;
        step();
        chk_out("t1_idle", 1'b0, 3'd0, 8'h00);

        // 2: three simultaneous requests granted high to low
        bus.req = 8'h8A;
        step();
        chk_out("t2_lat", 1'b0, 3'd0, 8'h8A);
        step();
        chk_out("t2_g7", 1'b1, 3'd7, 8'h8A);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk_out("t2_gap1", 1'b0, 3'd0, 8'h0A);
        step();
        chk_out("t2_g3", 1'b1, 3'd3, 8'h0A);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk_out("t2_gap2", 1'b0, 3'd0, 8'h02);
        step();
        chk_out("t2_g1", 1'b1, 3'd1, 8'h02);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk_out("t2_gap3", 1'b0, 3'd0, 8'h00);
        step();
        chk_out("t2_idle", 1'b0, 3'd0, 8'h00);
        bus.req = 8'h00;

        // 3: priority-level filter
        bus.cur_pl = 3'd4;
        bus.req    = 8'h14;
        step();
        chk_out("t3_lat", 1'b0, 3'd0, 8'h14);
        step();
        chk_out("t3_pl4a", 1'b0, 3'd0, 8'h14);
        step();
        chk_out("t3_pl4b", 1'b0, 3'd0, 8'h14);
        bus.cur_pl = 3'd3;
        step();
        chk_out("t3_g4", 1'b1, 3'd4, 8'h14);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk_out("t3_ack", 1'b0, 3'd0, 8'h04);
        step();
        chk_out("t3_pl3", 1'b0, 3'd0, 8'h04);
        bus.cur_pl = 3'd2;
        step();
        chk_out("t3_pl2", 1'b0, 3'd0, 8'h04);
        bus.cur_pl = 3'd1;
        step();
        chk_out("t3_g2", 1'b1, 3'd2, 8'h04);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk_out("t3_done", 1'b0, 3'd0, 8'h00);
        bus.req    = 8'h00;
        bus.cur_pl = 3'd0;

        // 4: masked pending bit is held, presented once unmasked
        bus.mask_we = 1'b1;
        bus.mask_in = 8'h7F;
        bus.req     = 8'h80;
        step();
        bus.mask_we = 1'b0;
        chk_out("t4_lat", 1'b0, 3'd0, 8'h80);
        step();
        chk_out("t4_mask1", 1'b0, 3'd0, 8'h80);
        step();
        chk_out("t4_mask2", 1'b0, 3'd0, 8'h80);
        bus.mask_we = 1'b1;
        bus.mask_in = 8'hFF;
        step();
        bus.mask_we = 1'b0;
        chk_out("t4_unmask", 1'b0, 3'd0, 8'h80);
        step();
        chk_out("t4_g7", 1'b1, 3'd7, 8'h80);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk_out("t4_done", 1'b0, 3'd0, 8'h00);
        bus.req = 8'h00;

        // 5: no preemption; then same-cycle rise and clear keeps the bit
        bus.req = 8'h08;
        step();
        step();
        chk_out("t5_g3", 1'b1, 3'd3, 8'h08);
        bus.req = 8'h48;
        step();
        chk_out("t5_hold1", 1'b1, 3'd3, 8'h48);
        step();
        chk_out("t5_hold2", 1'b1, 3'd3, 8'h48);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk_out("t5_ack3", 1'b0, 3'd0, 8'h40);
        step();
        chk_out("t5_g6", 1'b1, 3'd6, 8'h40);
        bus.req = 8'h08;
        step();
        chk_out("t5_g6b", 1'b1, 3'd6, 8'h40);
        bus.req     = 8'h48;
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk_out("t5_setwins", 1'b0, 3'd0, 8'h40);
        step();
        chk_out("t5_g6c", 1'b1, 3'd6, 8'h40);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk_out("t5_done", 1'b0, 3'd0, 8'h00);
        bus.req = 8'h00;
        step();

        // 6: reset while presenting, held line re-latched afterwards
        bus.req = 8'h30;
        step();
        chk_out("t6_lat", 1'b0, 3'd0, 8'h30);
        step();
        chk_out("t6_g5", 1'b1, 3'd5, 8'h30);
        rst = 1'b1;
        step();
        chk_out("t6_rst", 1'b0, 3'd0, 8'h00);
        rst = 1'b0;
        step();
        chk_out("t6_relatch", 1'b0, 3'd0, 8'h30);
        step();
        chk_out("t6_g5b", 1'b1, 3'd5, 8'h30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
